// File: rtl/display_pkg.sv
// Shared constants, scan-index enum and leading-zero helper for the
// seven-segment display path.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDX0 = 2'd0,
        IDX1 = 2'd1,
        IDX2 = 2'd2,
        IDX3 = 2'd3
    } scan_idx_e;

    // Bit i set when nibble i and every nibble above it are zero; digit 0 is never blanked.
    function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(input logic [15:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic zero_above;
        m = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (v[i*DIGIT_W +: DIGIT_W] == 4'h0);
            m[i] = zero_above;
        end
        return m;
    endfunction

endpackage

// File: rtl/display_prescaler.sv
// Free-running divider: tick is high for one cycle out of every REFRESH_DIV.
module display_prescaler #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit scanner: double-buffered value, committed only at the frame
// boundary, with registered digit/anode/dp outputs and leading-zero blanking.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  digit,
    output logic [3:0]  anode,
    output logic        dp,
    output logic        frame_start
);

    logic tick;

    display_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    scan_idx_e   idx, idx_nxt;
    logic [15:0] shadow, shadow_nxt, disp, disp_nxt;
    logic [3:0]  shadow_dp, shadow_dp_nxt, disp_dp, disp_dp_nxt;
    logic        pending, pending_nxt;
    logic [3:0]  digit_nxt, anode_nxt, blank;
    logic        dp_nxt, frame_start_nxt;
    logic        wrap, commit;

    always_comb begin
        idx_nxt         = idx;
        shadow_nxt      = shadow;
        shadow_dp_nxt   = shadow_dp;
        disp_nxt        = disp;
        disp_dp_nxt     = disp_dp;
        pending_nxt     = pending;
        digit_nxt       = digit;
        anode_nxt       = anode;
        dp_nxt          = dp;
        wrap            = tick && (idx == IDX3);
        commit          = wrap && (pending || load);
        frame_start_nxt = wrap;

        if (load) begin
            shadow_nxt    = value;
            shadow_dp_nxt = dp_en;
            pending_nxt   = 1'b1;
        end
        // A load landing on the wrap tick goes straight to the display.
        if (commit) begin
            disp_nxt    = load ? value : shadow;
            disp_dp_nxt = load ? dp_en : shadow_dp;
            pending_nxt = 1'b0;
        end

        blank = blank_lz ? lz_blank_mask(disp_nxt) : '0;

        if (tick) begin
            idx_nxt   = scan_idx_e'(idx + 2'd1);
            digit_nxt = disp_nxt[int'(idx_nxt)*DIGIT_W +: DIGIT_W];
            if (blank[idx_nxt]) begin
                anode_nxt = ANODE_OFF;
                dp_nxt    = 1'b1;
            end else begin
                anode_nxt = ~(4'b0001 << idx_nxt);
                dp_nxt    = ~disp_dp_nxt[idx_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= IDX0;
            shadow      <= '0;
            shadow_dp   <= '0;
            disp        <= '0;
            disp_dp     <= '0;
            pending     <= 1'b0;
            digit       <= 4'h0;
            anode       <= ANODE_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            shadow      <= shadow_nxt;
            shadow_dp   <= shadow_dp_nxt;
            disp        <= disp_nxt;
            disp_dp     <= disp_dp_nxt;
            pending     <= pending_nxt;
            digit       <= digit_nxt;
            anode       <= anode_nxt;
            dp          <= dp_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with REFRESH_DIV=4 (16-cycle frames).
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_en;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        dp;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    display_scan_mux #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .load        (load),
        .blank_lz    (blank_lz),
        .dp_en       (dp_en),
        .digit       (digit),
        .anode       (anode),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // One-cycle load strobe driven at a falling edge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_en = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Waits (bounded) for frame_start, then records slot k's first-cycle
    // outputs and whether they held unchanged for the whole 4-cycle slot.
    task automatic capture_frame(output bit found, output logic [3:0][3:0] dg,
                                 output logic [3:0][3:0] an, output logic [3:0] dpv,
                                 output bit stable);
        found = 1'b0; stable = 1'b1; dg = '0; an = '0; dpv = '0;
        for (int n = 0; n < 40 && frame_start !== 1'b1; n++) @(negedge clk);
        if (frame_start !== 1'b1) return;
        found = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dg[k] = digit; an[k] = anode; dpv[k] = dp;
            for (int c = 0; c < 4; c++) begin
                if (c > 0 && (digit !== dg[k] || anode !== an[k] || dp !== dpv[k] || frame_start !== 1'b0))
                    stable = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0; value = '0; dp_en = '0;
        repeat (3) @(negedge clk);
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL reset_digit got=%h want=0", digit); end
        checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL reset_anode got=%b want=1111", anode); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b want=1", dp); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b want=0", frame_start); end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        bit found, stable;
        logic [3:0][3:0] dg, an;
        logic [3:0] dpv;
        do_load(16'h1234, 4'b0000);
        checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL scan_pre_tick_anode got=%b want=1111", anode); end
        capture_frame(found, dg, an, dpv, stable);
        checks++; if (!found) begin errors++; $display("FAIL scan_frame_found got=0 want=1"); end
        checks++; if (!stable) begin errors++; $display("FAIL scan_hold got=0 want=1"); end
        checks++; if (dg !== 16'h1234) begin errors++; $display("FAIL scan_digits got=%h want=1234", dg); end
        checks++; if (an !== 16'h7BDE) begin errors++; $display("FAIL scan_anodes got=%h want=7bde", an); end
        checks++; if (dpv !== 4'b1111) begin errors++; $display("FAIL scan_dp got=%b want=1111", dpv); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL scan_frame_len got=%b want=1", frame_start); end
    endtask

    task automatic test_blank_dp();
        bit found, stable;
        logic [3:0][3:0] dg, an;
        logic [3:0] dpv;
        blank_lz = 1'b1;
        do_load(16'h00A0, 4'b0010);
        capture_frame(found, dg, an, dpv, stable);
        checks++; if (!found || !stable) begin errors++; $display("FAIL blank_frame got=%b%b want=11", found, stable); end
        checks++; if (dg !== 16'h00A0) begin errors++; $display("FAIL blank_digits got=%h want=00a0", dg); end
        checks++; if (an !== 16'hFFDE) begin errors++; $display("FAIL blank_anodes got=%h want=ffde", an); end
        checks++; if (dpv !== 4'b1101) begin errors++; $display("FAIL blank_dp got=%b want=1101", dpv); end
    endtask

    task automatic test_zero();
        bit found, stable;
        logic [3:0][3:0] dg, an;
        logic [3:0] dpv;
        do_load(16'h0000, 4'b0000);
        capture_frame(found, dg, an, dpv, stable);
        checks++; if (!found || !stable) begin errors++; $display("FAIL zero_frame got=%b%b want=11", found, stable); end
        checks++; if (an !== 16'hFFFE) begin errors++; $display("FAIL zero_lz_anodes got=%h want=fffe", an); end
        checks++; if (dg !== 16'h0000) begin errors++; $display("FAIL zero_lz_digits got=%h want=0000", dg); end
        checks++; if (dpv !== 4'b1111) begin errors++; $display("FAIL zero_lz_dp got=%b want=1111", dpv); end
        blank_lz = 1'b0;
        capture_frame(found, dg, an, dpv, stable);
        checks++; if (!found || !stable) begin errors++; $display("FAIL zero_nolz_frame got=%b%b want=11", found, stable); end
        checks++; if (an !== 16'h7BDE) begin errors++; $display("FAIL zero_nolz_anodes got=%h want=7bde", an); end
        checks++; if (dg !== 16'h0000) begin errors++; $display("FAIL zero_nolz_digits got=%h want=0000", dg); end
    endtask

    task automatic test_midframe_load();
        int n;
        bit stays_old;
        repeat (4) @(negedge clk);
        checks++; if (anode !== 4'b1101) begin errors++; $display("FAIL mid_at_idx1 got=%b want=1101", anode); end
        do_load(16'hBBBB, 4'b0000);
        n = 0; stays_old = 1'b1;
        while (frame_start !== 1'b1 && n < 20) begin
            if (digit !== 4'h0) stays_old = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++; if (n != 11) begin errors++; $display("FAIL mid_wait_cycles got=%0d want=11", n); end
        checks++; if (!stays_old) begin errors++; $display("FAIL mid_old_kept got=0 want=1"); end
        checks++; if (digit !== 4'hB) begin errors++; $display("FAIL mid_new_digit got=%h want=b", digit); end
        checks++; if (anode !== 4'b1110) begin errors++; $display("FAIL mid_new_anode got=%b want=1110", anode); end
    endtask

    task automatic test_back_to_back();
        bit found, stable;
        logic [3:0][3:0] dg, an;
        logic [3:0] dpv;
        do_load(16'h1111, 4'b0000);
        repeat (2) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        capture_frame(found, dg, an, dpv, stable);
        checks++; if (!found || !stable) begin errors++; $display("FAIL b2b_frame got=%b%b want=11", found, stable); end
        checks++; if (dg !== 16'h2222) begin errors++; $display("FAIL b2b_last_wins got=%h want=2222", dg); end
        // Now at cycle 0 of a frame; cycle 15 is the idx 3->0 tick cycle.
        repeat (15) @(negedge clk);
        do_load(16'h5678, 4'b0000);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL bypass_fs got=%b want=1", frame_start); end
        checks++; if (digit !== 4'h8) begin errors++; $display("FAIL bypass_digit got=%h want=8", digit); end
        capture_frame(found, dg, an, dpv, stable);
        checks++; if (!found || !stable) begin errors++; $display("FAIL bypass_frame got=%b%b want=11", found, stable); end
        checks++; if (dg !== 16'h5678) begin errors++; $display("FAIL bypass_digits got=%h want=5678", dg); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit found, stable;
        logic [3:0][3:0] dg, an;
        logic [3:0] dpv;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL rmid_anode got=%b want=1111", anode); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rmid_dp got=%b want=1", dp); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL rmid_digit got=%h want=0", digit); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rmid_fs got=%b want=0", frame_start); end
        rst_n = 1'b1;
        n = 0;
        while (anode === 4'b1111 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rmid_first_anode_cycles got=%0d want=4", n); end
        checks++; if (anode !== 4'b1101) begin errors++; $display("FAIL rmid_first_anode got=%b want=1101", anode); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL rmid_disp_cleared got=%h want=0", digit); end
        capture_frame(found, dg, an, dpv, stable);
        checks++; if (!found || dg !== 16'h0000) begin errors++; $display("FAIL rmid_frame got=%b/%h want=1/0000", found, dg); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_dp();
        test_zero();
        test_midframe_load();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Four-digit time-multiplexed scanner that sits directly upstream of the seven-segment decoder.
- Holds a 16-bit hex/BCD value and cycles through its nibbles at a programmable refresh rate.
- Presents one 4-bit code at a time to the decoder and drives the matching active-low anode enable and decimal point.
- Uses shadow/display double-buffering so a new value is shown only at a frame boundary, with no tearing.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot. Minimum 2. Counter width is $clog2(REFRESH_DIV).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- value  input  16  digit codes; nibble 0 = rightmost digit
- load  input  1  one-cycle strobe; captures value and dp_en into the shadow registers
- blank_lz  input  1  1 = suppress leading zeros
- dp_en  input  4  per-digit decimal-point enable, bit i = digit i
- digit  output  4  code for the seven-segment decoder
- anode  output  4  active-low digit enables, bit i = digit i
- dp  output  1  active-low decimal point
- frame_start  output  1  one-cycle pulse when scanning re-enters digit 0

Behaviour:
- Reset is synchronous and active-low, sampled on the rising edge of clk. While rst_n=0:
  - prescaler = 0, idx = 0
  - shadow = 0, shadow_dp = 0, disp = 0, disp_dp = 0, pending = 0
  - digit = 4'h0, anode = 4'b1111, dp = 1, frame_start = 0
- Reset asserted mid-scan takes effect on the next edge. The first anode assertion after reset release occurs on the first tick.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
- Scan index:
  - idx is 2 bits. On tick, idx <= idx+1, wrapping 3 -> 0.
  - Each digit is shown for exactly REFRESH_DIV cycles; a full frame is 4*REFRESH_DIV cycles.
- Load:
  - On load=1: shadow <= value, shadow_dp <= dp_en, pending <= 1.
  - Back-to-back loads: the last one wins.
- Frame commit:
  - On a tick where idx==3 (next idx is 0) and pending=1: disp <= shadow, disp_dp <= shadow_dp, pending <= 0.
  - If load coincides with that tick, the commit uses the incoming value/dp_en directly (bypass), and pending ends at 0.
- Outputs:
  - All outputs are registered and update on the same edge as idx, from the next idx and the post-commit disp.
  - digit = disp nibble[next idx]; dp = ~disp_dp[next idx].
  - anode = ~(1 << next idx), unless that position is blanked, in which case anode = 4'b1111.
  - Between ticks, outputs hold.
- frame_start = 1 for exactly the one cycle following a tick that moves idx 3 -> 0.
- Leading-zero blanking:
  - With blank_lz=1, position i (3..1) is blanked when disp[4i+3:4i] == 0 and every higher nibble == 0.
  - Position 0 is never blanked.
  - A blanked position drives anode 4'b1111 and dp=1 regardless of dp_en.
  - blank_lz is sampled live at each tick.
- disp is never modified except by a frame commit or reset.

Decomposition:
- Shared package display_pkg holds:
  - NUM_DIGITS = 4
  - ANODE_OFF = 4'b1111
  - DIGIT_W = 4
  - the enum for scan index
- One sub-module is natural: display_prescaler, a parameterised tick generator (REFRESH_DIV counter, tick out). It is reusable by later debounce and blink blocks.

Test Plan (REFRESH_DIV=4):
- Reset, then load value=16'h1234 → after the first frame commit, successive ticks show (digit, anode) = (4,1110), (3,1101), (2,1011), (1,0111), each held exactly 4 cycles.
- Load 16'h00A0 with blank_lz=1, dp_en=4'b0010 → anode 3 and anode 2 are never asserted; digit 1 shows A with dp=0; digit 0 shows 0 with dp=1.
- Load 16'h0000 with blank_lz=1 → only anode[0] is ever asserted, showing 0. With blank_lz=0, all four anodes cycle showing 0.
- Load 16'hBBBB mid-frame at idx=1 → the display keeps the old value until idx wraps to 0, and frame_start pulses on the same cycle that digit becomes B.
- Load 16'h1111 then 16'h2222 within one frame → only 2222 is ever displayed. A load coincident with the idx 3->0 tick is displayed immediately, with no extra frame of delay.
- Assert rst_n=0 for 1 cycle mid-scan → next edge gives anode=1111, dp=1, digit=0. After release, the first anode asserts after exactly 4 cycles and disp=0.
